// File: rtl/gx_reset_seq_if.sv
// Status and reset bundle between the transceiver channels and the reset sequencer.
// The master drives the transceiver status; the slave (sequencer) drives the resets.
interface gx_reset_seq_if #(
  parameter int unsigned CH_N = 4
);
  logic            gx_pll_locked_i;
  logic [CH_N-1:0] gx_tx_cal_busy_i;
  logic [CH_N-1:0] gx_rx_cal_busy_i;
  logic [CH_N-1:0] gx_rx_is_lockedtodata_i;
  logic [CH_N-1:0] gx_tx_analogreset_o;
  logic [CH_N-1:0] gx_tx_digitalreset_o;
  logic [CH_N-1:0] gx_rx_analogreset_o;
  logic [CH_N-1:0] gx_rx_digitalreset_o;
  logic [CH_N-1:0] tx_ready_o;
  logic [CH_N-1:0] rx_ready_o;

  modport master (
    output gx_pll_locked_i, gx_tx_cal_busy_i, gx_rx_cal_busy_i, gx_rx_is_lockedtodata_i,
    input  gx_tx_analogreset_o, gx_tx_digitalreset_o, gx_rx_analogreset_o,
           gx_rx_digitalreset_o, tx_ready_o, rx_ready_o
  );

  modport slave (
    input  gx_pll_locked_i, gx_tx_cal_busy_i, gx_rx_cal_busy_i, gx_rx_is_lockedtodata_i,
    output gx_tx_analogreset_o, gx_tx_digitalreset_o, gx_rx_analogreset_o,
           gx_rx_digitalreset_o, tx_ready_o, rx_ready_o
  );
endinterface

// File: rtl/gx_reset_seq.sv
// Multi-channel Cyclone 10 GX transceiver reset sequencer: TX/RX analog and digital resets
// released in order from synchronised calibration, PLL-lock and CDR-lock status.
module gx_reset_seq #(
  parameter int unsigned CH_N      = 4,
  parameter int unsigned TX_BONDED = 1,
  parameter int unsigned ANA_CYC   = 100,
  parameter int unsigned DIG_CYC   = 20,
  parameter int unsigned LTD_CYC   = 250
) (
  input  logic           clk_50m,
  input  logic           io_reset_i,
  gx_reset_seq_if.slave  gx
);

  localparam int unsigned MAX_AD  = (ANA_CYC > DIG_CYC) ? ANA_CYC : DIG_CYC;
  localparam int unsigned CNT_MAX = (MAX_AD > LTD_CYC) ? MAX_AD : LTD_CYC;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned TX_N    = (TX_BONDED != 0) ? 1 : CH_N;

  localparam logic [CNT_W-1:0] CNT_TOP  = CNT_W'(CNT_MAX);
  localparam logic [CNT_W-1:0] ANA_LAST = CNT_W'(ANA_CYC - 1);
  localparam logic [CNT_W-1:0] DIG_LAST = CNT_W'(DIG_CYC - 1);
  localparam logic [CNT_W-1:0] LTD_LAST = CNT_W'(LTD_CYC - 1);

  typedef enum logic [1:0] {TX_RST, TX_ANA, TX_DIG, TX_RDY} tx_state_e;
  typedef enum logic [1:0] {RX_RST, RX_ANA, RX_LTD, RX_RDY} rx_state_e;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_TOP) ? v : v + CNT_W'(1);
  endfunction

  logic            pll_s1_q, pll_s2_q;
  logic [CH_N-1:0] txb_s1_q, txb_s2_q;
  logic [CH_N-1:0] rxb_s1_q, rxb_s2_q;
  logic [CH_N-1:0] ltd_s1_q, ltd_s2_q;

  // Two-flop synchronisers for every asynchronous status input
  always_ff @(posedge clk_50m or posedge io_reset_i) begin
    if (io_reset_i) begin
      pll_s1_q <= 1'b0;
      pll_s2_q <= 1'b0;
      txb_s1_q <= '0;
      txb_s2_q <= '0;
      rxb_s1_q <= '0;
      rxb_s2_q <= '0;
      ltd_s1_q <= '0;
      ltd_s2_q <= '0;
    end else begin
      pll_s1_q <= gx.gx_pll_locked_i;
      pll_s2_q <= pll_s1_q;
      txb_s1_q <= gx.gx_tx_cal_busy_i;
      txb_s2_q <= txb_s1_q;
      rxb_s1_q <= gx.gx_rx_cal_busy_i;
      rxb_s2_q <= rxb_s1_q;
      ltd_s1_q <= gx.gx_rx_is_lockedtodata_i;
      ltd_s2_q <= ltd_s1_q;
    end
  end

  logic [TX_N-1:0] tx_ana_v, tx_dig_v, tx_rdy_v;
  logic            tx_busy_any_c;

  assign tx_busy_any_c = |txb_s2_q;

  for (genvar t = 0; t < TX_N; t++) begin : g_tx
    tx_state_e        state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             ana_q, dig_q, rdy_q;
    logic             ok_c;

    // A bonded group is only as healthy as its busiest channel
    assign ok_c = pll_s2_q & ~((TX_BONDED != 0) ? tx_busy_any_c : txb_s2_q[t]);

    always_ff @(posedge clk_50m or posedge io_reset_i) begin
      if (io_reset_i) begin
        state_q <= TX_RST;
        cnt_q   <= '0;
        ana_q   <= 1'b1;
        dig_q   <= 1'b1;
        rdy_q   <= 1'b0;
      end else if (state_q != TX_RST && !ok_c) begin
        state_q <= TX_RST;
        cnt_q   <= '0;
        ana_q   <= 1'b1;
        dig_q   <= 1'b1;
        rdy_q   <= 1'b0;
      end else begin
        case (state_q)
          TX_RST: begin
            cnt_q <= '0;
            if (ok_c) state_q <= TX_ANA;
          end
          TX_ANA: begin
            if (cnt_q == ANA_LAST) begin
              state_q <= TX_DIG;
              cnt_q   <= '0;
              ana_q   <= 1'b0;
            end else begin
              cnt_q <= sat_inc(cnt_q);
            end
          end
          TX_DIG: begin
            if (cnt_q == DIG_LAST) begin
              state_q <= TX_RDY;
              cnt_q   <= '0;
              dig_q   <= 1'b0;
              rdy_q   <= 1'b1;
            end else begin
              cnt_q <= sat_inc(cnt_q);
            end
          end
          TX_RDY: cnt_q <= '0;
        endcase
      end
    end

    assign tx_ana_v[t] = ana_q;
    assign tx_dig_v[t] = dig_q;
    assign tx_rdy_v[t] = rdy_q;
  end

  for (genvar c = 0; c < CH_N; c++) begin : g_ch
    localparam int unsigned SRC = (TX_BONDED != 0) ? 0 : c;

    rx_state_e        state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             ana_q, dig_q, rdy_q;

    assign gx.gx_tx_analogreset_o[c]  = tx_ana_v[SRC];
    assign gx.gx_tx_digitalreset_o[c] = tx_dig_v[SRC];
    assign gx.tx_ready_o[c]           = tx_rdy_v[SRC];

    // RX sequencing; CDR lock loss only re-arms the digital reset
    always_ff @(posedge clk_50m or posedge io_reset_i) begin
      if (io_reset_i) begin
        state_q <= RX_RST;
        cnt_q   <= '0;
        ana_q   <= 1'b1;
        dig_q   <= 1'b1;
        rdy_q   <= 1'b0;
      end else if (state_q != RX_RST && rxb_s2_q[c]) begin
        state_q <= RX_RST;
        cnt_q   <= '0;
        ana_q   <= 1'b1;
        dig_q   <= 1'b1;
        rdy_q   <= 1'b0;
      end else begin
        case (state_q)
          RX_RST: begin
            cnt_q <= '0;
            if (!rxb_s2_q[c]) state_q <= RX_ANA;
          end
          RX_ANA: begin
            if (cnt_q == ANA_LAST) begin
              state_q <= RX_LTD;
              cnt_q   <= '0;
              ana_q   <= 1'b0;
            end else begin
              cnt_q <= sat_inc(cnt_q);
            end
          end
          RX_LTD: begin
            if (!ltd_s2_q[c]) begin
              cnt_q <= '0;
            end else if (cnt_q == LTD_LAST) begin
              state_q <= RX_RDY;
              cnt_q   <= '0;
              dig_q   <= 1'b0;
              rdy_q   <= 1'b1;
            end else begin
              cnt_q <= sat_inc(cnt_q);
            end
          end
          RX_RDY: begin
            cnt_q <= '0;
            if (!ltd_s2_q[c]) begin
              state_q <= RX_LTD;
              dig_q   <= 1'b1;
              rdy_q   <= 1'b0;
            end
          end
        endcase
      end
    end

    assign gx.gx_rx_analogreset_o[c]  = ana_q;
    assign gx.gx_rx_digitalreset_o[c] = dig_q;
    assign gx.rx_ready_o[c]           = rdy_q;
  end

endmodule
